// File: rtl/truth_table_sweep.sv
// truth_table_sweep
//   Drives every input combination of an external N_IN-input logic block,
//   waits SETTLE idle cycles per combination, samples its response and
//   assembles the full truth table.
//
//   Parameters
//     N_IN    number of stimulus inputs (1..6)
//     SETTLE  idle cycles between driving a stimulus and sampling (0..15)
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     start        level-sampled request for a full sweep (ignored while busy)
//     stim_out     stimulus index {inN,...,in1} applied to the logic under test
//     resp_in      response of the logic under test
//     busy         high while a sweep is in progress
//     done         one-cycle pulse when table_out has been updated
//     table_out    last completed truth table, bit k = response to index k
//     expected_in  golden table, captured when a sweep starts  (compare build)
//     mismatch     captured table differed from golden table   (compare build)
//
//   Optional feature: define TRUTH_TABLE_SWEEP_COMPARE_EN to add the golden
//   table comparison (expected_in / mismatch ports).
module truth_table_sweep #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        stim_out,
  input  logic                   resp_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_out
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
  ,
  input  logic [(1<<N_IN)-1:0]   expected_in,
  output logic                   mismatch
`endif
);

  localparam int                W           = 1 << N_IN;
  localparam logic [N_IN-1:0]   LAST_INDEX  = {N_IN{1'b1}};
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [N_IN-1:0] index, index_next;
  logic [3:0]      settle_cnt, settle_next;
  logic [W-1:0]    capture, capture_next;
  logic [W-1:0]    table_next;
  logic [W-1:0]    full_table;
  logic            done_next;

  // The index register doubles as the stimulus, and the state register as
  // busy, so both outputs come straight from flops.
  assign stim_out = index;
  assign busy     = (state == RUN);

  // Captured table with the current response merged in; this is what gets
  // stored on the sampling edge, and on the final edge it is the full table.
  always_comb begin
    full_table        = capture;
    full_table[index] = resp_in;
  end

  // Next-state and datapath updates. Each index is held for SETTLE+1 cycles;
  // the edge that ends the window samples the response and, unless this was
  // the last index, moves straight on to the next one with no gap cycle.
  always_comb begin
    state_next   = state;
    index_next   = index;
    settle_next  = settle_cnt;
    capture_next = capture;
    table_next   = table_out;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          index_next   = '0;
          settle_next  = '0;
          capture_next = '0;
        end
      end
      RUN: begin
        if (settle_cnt == SETTLE_LAST) begin
          settle_next  = '0;
          capture_next = full_table;
          if (index == LAST_INDEX) begin
            state_next = IDLE;
            index_next = '0;
            table_next = full_table;
            done_next  = 1'b1;
          end else begin
            index_next = index + 1'b1;
          end
        end else begin
          settle_next = settle_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end

  // State and datapath registers; reset wins over any sweep activity, so an
  // interrupted sweep leaves no done pulse and a cleared table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      index      <= '0;
      settle_cnt <= '0;
      capture    <= '0;
      table_out  <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      index      <= index_next;
      settle_cnt <= settle_next;
      capture    <= capture_next;
      table_out  <= table_next;
      done       <= done_next;
    end
  end

`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
  logic [W-1:0] expected_reg;

  // The golden table is latched when the sweep is accepted so that it may
  // change freely during RUN; the verdict is produced on the done edge and
  // held until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      expected_reg <= '0;
      mismatch     <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        expected_reg <= expected_in;
      end
      if (done_next) begin
        mismatch <= (full_table != expected_reg);
      end
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep
//   Directed bench for truth_table_sweep. Instance dut0 uses the defaults and
//   is fed by the 3-input function with table 8'h97; instance dut1 uses
//   SETTLE=0 and is fed by in1 alone (table 8'hAA).
module tb_truth_table_sweep;

  logic       clk;
  logic       rst;
  logic       start0;
  logic       start1;
  logic [2:0] stim0;
  logic [2:0] stim1;
  logic       resp0;
  logic       resp1;
  logic       busy0;
  logic       busy1;
  logic       done0;
  logic       done1;
  logic [7:0] table0;
  logic [7:0] table1;
  logic [7:0] func_table;
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
  logic [7:0] expected0;
  logic [7:0] expected1;
  logic       mismatch0;
  logic       mismatch1;
`endif

  int checks;
  int failures;

  // Logic under test models: dut0 sees a fixed lookup table, dut1 sees in1.
  assign resp0 = func_table[stim0];
  assign resp1 = stim1[0];

  truth_table_sweep #(.N_IN(3), .SETTLE(2)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .stim_out   (stim0),
    .resp_in    (resp0),
    .busy       (busy0),
    .done       (done0),
    .table_out  (table0)
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    ,
    .expected_in(expected0),
    .mismatch   (mismatch0)
`endif
  );

  truth_table_sweep #(.N_IN(3), .SETTLE(0)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .stim_out   (stim1),
    .resp_in    (resp1),
    .busy       (busy1),
    .done       (done1),
    .table_out  (table1)
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    ,
    .expected_in(expected1),
    .mismatch   (mismatch1)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it; inputs are
  // driven and outputs sampled at that point, away from the edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the shared control inputs.
  task automatic applyStimulus(input logic r, input logic s0, input logic s1);
    rst    = r;
    start0 = s0;
    start1 = s1;
  endtask

  // One comparison: counts it, and on a miss counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    func_table = 8'h97;
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    expected0  = 8'h00;
    expected1  = 8'h00;
`endif

    // Reset state, with start asserted to show reset takes priority.
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycle();
    stepCycle();
    checkOutput("reset_stim0", 64'(stim0), 64'd0);
    checkOutput("reset_busy0", 64'(busy0), 64'd0);
    checkOutput("reset_done0", 64'(done0), 64'd0);
    checkOutput("reset_table0", 64'(table0), 64'd0);
    checkOutput("reset_busy1", 64'(busy1), 64'd0);
    checkOutput("reset_table1", 64'(table1), 64'd0);
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    checkOutput("reset_mismatch0", 64'(mismatch0), 64'd0);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle();
    stepCycle();
    checkOutput("idle_wait_busy0", 64'(busy0), 64'd0);

    // Default sweep: start accepted at E0, each index held 3 cycles.
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    expected0 = 8'h97;
`endif
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    expected0 = 8'h00;
`endif
    for (int c = 0; c < 24; c++) begin
      checkOutput("sweep_stim", 64'(stim0), 64'(c / 3));
      checkOutput("sweep_busy", 64'(busy0), 64'd1);
      checkOutput("sweep_done_low", 64'(done0), 64'd0);
      checkOutput("sweep_table_hold", 64'(table0), 64'd0);
      stepCycle();
    end
    checkOutput("e24_done", 64'(done0), 64'd1);
    checkOutput("e24_busy", 64'(busy0), 64'd0);
    checkOutput("e24_stim", 64'(stim0), 64'd0);
    checkOutput("e24_table", 64'(table0), 64'h97);
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    checkOutput("e24_mismatch", 64'(mismatch0), 64'd0);
`endif
    stepCycle();
    checkOutput("e25_done_pulse_end", 64'(done0), 64'd0);
    checkOutput("e25_table_hold", 64'(table0), 64'h97);
    checkOutput("e25_stim_idle", 64'(stim0), 64'd0);

    // SETTLE=0 sweep on dut1: one cycle per index, done at E8.
    applyStimulus(1'b0, 1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      checkOutput("s0_stim", 64'(stim1), 64'(c));
      checkOutput("s0_done_low", 64'(done1), 64'd0);
      stepCycle();
    end
    checkOutput("s0_done", 64'(done1), 64'd1);
    checkOutput("s0_table", 64'(table1), 64'hAA);
    checkOutput("s0_busy", 64'(busy1), 64'd0);

    // Reset at E10 of a sweep that follows a completed 8'h97 table.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 9; c++) stepCycle();
    checkOutput("e9_table_hold", 64'(table0), 64'h97);
    checkOutput("e9_stim", 64'(stim0), 64'd3);
    checkOutput("e9_busy", 64'(busy0), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midrst_busy", 64'(busy0), 64'd0);
    checkOutput("midrst_table", 64'(table0), 64'd0);
    checkOutput("midrst_stim", 64'(stim0), 64'd0);
    checkOutput("midrst_done", 64'(done0), 64'd0);
    for (int c = 0; c < 30; c++) begin
      stepCycle();
      checkOutput("midrst_no_done", 64'(done0), 64'd0);
    end

    // Fresh sweep after reset, golden table deliberately off by one bit.
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    expected0 = 8'h96;
`endif
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 23; c++) stepCycle();
    checkOutput("resweep_e23_done", 64'(done0), 64'd0);
    stepCycle();
    checkOutput("resweep_done", 64'(done0), 64'd1);
    checkOutput("resweep_table", 64'(table0), 64'h97);
`ifdef TRUTH_TABLE_SWEEP_COMPARE_EN
    checkOutput("resweep_mismatch", 64'(mismatch0), 64'd1);
`endif

    // Start held high from the done cycle onward: the sweep restarts on the
    // edge ending the done cycle, and starts seen during RUN change nothing.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("b2b_restart_busy", 64'(busy0), 64'd1);
    checkOutput("b2b_restart_stim", 64'(stim0), 64'd0);
    for (int c = 0; c < 23; c++) begin
      stepCycle();
      checkOutput("b2b_first_no_done", 64'(done0), 64'd0);
    end
    stepCycle();
    checkOutput("b2b_first_done", 64'(done0), 64'd1);
    checkOutput("b2b_first_busy", 64'(busy0), 64'd0);
    checkOutput("b2b_first_table", 64'(table0), 64'h97);
    stepCycle();
    checkOutput("b2b_second_busy", 64'(busy0), 64'd1);
    checkOutput("b2b_second_done_low", 64'(done0), 64'd0);
    for (int c = 0; c < 23; c++) begin
      stepCycle();
      checkOutput("b2b_second_no_done", 64'(done0), 64'd0);
    end
    stepCycle();
    checkOutput("b2b_second_done", 64'(done0), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("b2b_stop_busy", 64'(busy0), 64'd0);
    checkOutput("b2b_stop_done", 64'(done0), 64'd0);
    checkOutput("b2b_stop_table", 64'(table0), 64'h97);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
